// File: rtl/transposed_fir_stream_if.sv
// -----------------------------------------------------------------------------
// transposed_fir_stream_if
//
// Bundles the sample stream, coefficient-load bus, control strobes and the
// filtered output of transposed_fir_stream into one interface.
//
//   master : the side that feeds samples/coefficients and watches the output
//   slave  : the filter itself
//
// Signals
//   i_valid, din, i_ovr      input sample, its valid and upstream overflow tag
//   flush                    synchronous clear of filter state and output
//   coef_we, coef_addr,
//   coef_data                write one coefficient into the shadow bank
//   coef_commit              copy shadow bank into active bank
//   ovr_clr                  clear the sticky overflow flag
//   o_valid, dout, o_ovr     registered filtered sample, valid and overflow tag
//   o_ovr_sticky             sticky overflow flag
// -----------------------------------------------------------------------------
interface transposed_fir_stream_if #(
  parameter int WIDTH = 16,
  parameter int TAPS  = 8
);
  localparam int AW = $clog2(TAPS);

  logic                    i_valid;
  logic signed [WIDTH-1:0] din;
  logic                    i_ovr;
  logic                    flush;
  logic                    coef_we;
  logic [AW-1:0]           coef_addr;
  logic signed [WIDTH-1:0] coef_data;
  logic                    coef_commit;
  logic                    ovr_clr;
  logic                    o_valid;
  logic signed [WIDTH-1:0] dout;
  logic                    o_ovr;
  logic                    o_ovr_sticky;

  modport master (
    output i_valid, din, i_ovr, flush, coef_we, coef_addr, coef_data,
           coef_commit, ovr_clr,
    input  o_valid, dout, o_ovr, o_ovr_sticky
  );

  modport slave (
    input  i_valid, din, i_ovr, flush, coef_we, coef_addr, coef_data,
           coef_commit, ovr_clr,
    output o_valid, dout, o_ovr, o_ovr_sticky
  );
endinterface

// File: rtl/transposed_fir_stream.sv
// -----------------------------------------------------------------------------
// transposed_fir_stream
//
// Valid-gated transposed-form FIR with a double-buffered coefficient bank,
// round-half-up output conversion (saturating or wrapping), a registered
// output with valid, a per-sample overflow tag and a sticky overflow flag.
//
// Samples, coefficients and dout are signed WIDTH-bit values with FRAC
// fractional bits. Products are kept at full precision and summed in an
// accumulator of 2*WIDTH + $clog2(TAPS) bits, so no internal overflow occurs.
//
// Ports
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset (clears outputs, sums and both banks)
//   bus   transposed_fir_stream_if.slave (stream, coefficient bus, strobes)
// -----------------------------------------------------------------------------
module transposed_fir_stream #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 15,
  parameter int TAPS     = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  transposed_fir_stream_if.slave  bus
);

  localparam int ACC = 2 * WIDTH + $clog2(TAPS);

  typedef logic signed [WIDTH-1:0] coef_t;
  typedef logic signed [ACC-1:0]   acc_t;

  // Rounding constant 2^(FRAC-1) and the signed WIDTH range seen in ACC bits.
  localparam acc_t  RND      = acc_t'(1) << (FRAC - 1);
  localparam acc_t  RANGE_MAX = {{(ACC-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam acc_t  RANGE_MIN = {{(ACC-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam coef_t SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam coef_t SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  coef_t shadow_q [TAPS];
  coef_t shadow_d [TAPS];
  coef_t active_q [TAPS];

  // s_q[j] holds the partial sum feeding tap j-1; s_q[TAPS-1] is the tail.
  acc_t  s_q [1:TAPS-1];
  acc_t  prod [TAPS];

  acc_t  acc;
  acc_t  shifted;
  logic  conv_ovf;
  coef_t conv_val;
  logic  ovr_next;
  logic  accept;

  // ---------------------------------------------------------------------------
  // Shadow bank next value: a write in the commit cycle is seen by the commit.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      shadow_d[k] = shadow_q[k];
    end
    if (bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
      shadow_d[bus.coef_addr] = bus.coef_data;
    end
  end

  // NOTE: the coefficient banks are small register arrays, not RAM, so they
  // are reset explicitly; a fresh block must filter with all-zero taps.
  // Sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= shadow_d[k];
        if (bus.coef_commit) begin
          active_q[k] <= shadow_d[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: full-precision products against the active bank, newest-sample
  // sum, then round-half-up and range conversion.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = acc_t'(bus.din) * acc_t'(active_q[k]);
    end

    acc     = prod[0] + s_q[1];
    shifted = (acc + RND) >>> FRAC;

    conv_ovf = (shifted > RANGE_MAX) || (shifted < RANGE_MIN);
    conv_val = shifted[WIDTH-1:0];
    if (conv_ovf && SATURATE) begin
      conv_val = shifted[ACC-1] ? SAT_MIN : SAT_MAX;
    end

    ovr_next = bus.i_ovr | conv_ovf;
    // Flush wins over a sample presented in the same cycle.
    accept   = bus.i_valid && !bus.flush;
  end

  // ---------------------------------------------------------------------------
  // Partial sums and registered output.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 1; j < TAPS; j++) begin
        s_q[j] <= '0;
      end
      bus.o_valid <= 1'b0;
      bus.dout    <= '0;
      bus.o_ovr   <= 1'b0;
    end else if (bus.flush) begin
      for (int j = 1; j < TAPS; j++) begin
        s_q[j] <= '0;
      end
      bus.o_valid <= 1'b0;
      bus.dout    <= '0;
      bus.o_ovr   <= 1'b0;
    end else if (bus.i_valid) begin
      for (int j = 1; j < TAPS - 1; j++) begin
        s_q[j] <= prod[j] + s_q[j+1];
      end
      s_q[TAPS-1] <= prod[TAPS-1];
      bus.o_valid <= 1'b1;
      bus.dout    <= conv_val;
      bus.o_ovr   <= ovr_next;
    end else begin
      // Idle cycle: sums, dout and o_ovr hold; only the valid drops.
      bus.o_valid <= 1'b0;
    end
  end

  // Sticky flag: setting (an o_ovr write of 1) beats a simultaneous clear.
  // Flush does not touch it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.o_ovr_sticky <= 1'b0;
    end else if (accept && ovr_next) begin
      bus.o_ovr_sticky <= 1'b1;
    end else if (bus.ovr_clr) begin
      bus.o_ovr_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_transposed_fir_stream.sv
// -----------------------------------------------------------------------------
// tb_transposed_fir_stream
//
// Directed bench for transposed_fir_stream with TAPS=4, WIDTH=16, FRAC=15.
// Two instances share the same stimulus: one saturating, one wrapping.
// Expected values are hand-computed Q1.15 results.
// -----------------------------------------------------------------------------
module tb_transposed_fir_stream;

  localparam int WIDTH = 16;
  localparam int FRAC  = 15;
  localparam int TAPS  = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        i_valid, i_ovr, flush, coef_we, coef_commit, ovr_clr;
  logic [15:0] din, coef_data;
  logic [1:0]  coef_addr;

  transposed_fir_stream_if #(.WIDTH(WIDTH), .TAPS(TAPS)) sat_if ();
  transposed_fir_stream_if #(.WIDTH(WIDTH), .TAPS(TAPS)) wrap_if ();

  assign sat_if.i_valid      = i_valid;
  assign sat_if.din          = din;
  assign sat_if.i_ovr        = i_ovr;
  assign sat_if.flush        = flush;
  assign sat_if.coef_we      = coef_we;
  assign sat_if.coef_addr    = coef_addr;
  assign sat_if.coef_data    = coef_data;
  assign sat_if.coef_commit  = coef_commit;
  assign sat_if.ovr_clr      = ovr_clr;

  assign wrap_if.i_valid     = i_valid;
  assign wrap_if.din         = din;
  assign wrap_if.i_ovr       = i_ovr;
  assign wrap_if.flush       = flush;
  assign wrap_if.coef_we     = coef_we;
  assign wrap_if.coef_addr   = coef_addr;
  assign wrap_if.coef_data   = coef_data;
  assign wrap_if.coef_commit = coef_commit;
  assign wrap_if.ovr_clr     = ovr_clr;

  transposed_fir_stream #(
    .WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS), .SATURATE(1'b1)
  ) u_sat (
    .clk  (clk),
    .rstn (rstn),
    .bus  (sat_if)
  );

  transposed_fir_stream #(
    .WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS), .SATURATE(1'b0)
  ) u_wrap (
    .clk  (clk),
    .rstn (rstn),
    .bus  (wrap_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] imp [5] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0000};

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    i_valid     = 1'b0;
    i_ovr       = 1'b0;
    din         = '0;
    flush       = 1'b0;
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_data   = '0;
    coef_commit = 1'b0;
    ovr_clr     = 1'b0;
  endtask

  // One clock: inputs set before the call are applied at the edge, outputs
  // are then sampled 1 time unit later, and one-shot inputs are cleared.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic sample(input logic [15:0] d);
    i_valid = 1'b1;
    din     = d;
    tick();
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rstn = 1'b1;

    // ---- Reset state ---------------------------------------------------------
    #2 rstn = 1'b0;
    #1;
    check("rst.o_valid", 16'(sat_if.o_valid), 16'h0);
    check("rst.dout",    sat_if.dout,         16'h0);
    check("rst.o_ovr",   16'(sat_if.o_ovr),   16'h0);
    check("rst.sticky",  16'(sat_if.o_ovr_sticky), 16'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // First sample after reset sees all-zero coefficients.
    sample(16'h7FFF);
    check("zero_coef.o_valid", 16'(sat_if.o_valid), 16'h1);
    check("zero_coef.dout",    sat_if.dout,         16'h0);

    // ---- Impulse response ----------------------------------------------------
    write_coef(2'd0, 16'h4000);
    write_coef(2'd1, 16'h2000);
    write_coef(2'd2, 16'h1000);
    write_coef(2'd3, 16'h0800);
    coef_commit = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      sample((i == 0) ? 16'h7FFF : 16'h0000);
      check($sformatf("imp%0d.o_valid", i), 16'(sat_if.o_valid), 16'h1);
      check($sformatf("imp%0d.dout", i),    sat_if.dout,         imp[i]);
      check($sformatf("imp%0d.o_ovr", i),   16'(sat_if.o_ovr),   16'h0);
    end

    // ---- Impulse with 3-cycle valid gaps -------------------------------------
    for (int i = 0; i < 5; i++) begin
      sample((i == 0) ? 16'h7FFF : 16'h0000);
      check($sformatf("gap%0d.o_valid", i), 16'(sat_if.o_valid), 16'h1);
      check($sformatf("gap%0d.dout", i),    sat_if.dout,         imp[i]);
      for (int g = 0; g < 3; g++) begin
        tick();
        check($sformatf("gap%0d_%0d.o_valid", i, g), 16'(sat_if.o_valid), 16'h0);
        check($sformatf("gap%0d_%0d.dout", i, g),    sat_if.dout,         imp[i]);
      end
    end

    // ---- Shadow write without commit leaves outputs unchanged ---------------
    write_coef(2'd0, 16'h1000);
    sample(16'h7FFF);
    check("nocommit.dout", sat_if.dout, 16'h4000);
    repeat (3) sample(16'h0000);

    // ---- Commit with a sample: that sample uses the old bank -----------------
    coef_commit = 1'b1;
    sample(16'h7FFF);
    check("commit_old.dout", sat_if.dout, 16'h4000);
    // New c0=0x1000 plus old c1=0x2000 tail: 12288*32767 rounded -> 0x3000.
    sample(16'h7FFF);
    check("commit_new.dout", sat_if.dout, 16'h3000);
    repeat (3) sample(16'h0000);

    // ---- Write and commit in the same cycle ----------------------------------
    coef_we     = 1'b1;
    coef_addr   = 2'd0;
    coef_data   = 16'h0800;
    coef_commit = 1'b1;
    tick();
    sample(16'h7FFF);
    check("wr_commit.dout", sat_if.dout, 16'h0800);

    // ---- Flush mid-impulse (sample in flush cycle is dropped) ----------------
    sample(16'h0000);
    check("pre_flush.dout", sat_if.dout, 16'h2000);
    flush   = 1'b1;
    i_valid = 1'b1;
    din     = 16'h7FFF;
    tick();
    check("flush.o_valid", 16'(sat_if.o_valid), 16'h0);
    check("flush.dout",    sat_if.dout,         16'h0);
    sample(16'h0000);
    check("flush_tail1.dout", sat_if.dout, 16'h0);
    sample(16'h0000);
    check("flush_tail2.dout", sat_if.dout, 16'h0);

    // ---- Saturation / wrap, all coefficients 0x7FFF --------------------------
    for (int k = 0; k < TAPS; k++) write_coef(2'(k), 16'h7FFF);
    coef_commit = 1'b1;
    tick();
    sample(16'h7FFF);
    check("pos1.sat.dout",   sat_if.dout,              16'h7FFE);
    check("pos1.sat.o_ovr",  16'(sat_if.o_ovr),        16'h0);
    check("pos1.sat.sticky", 16'(sat_if.o_ovr_sticky), 16'h0);
    check("pos1.wrap.dout",  wrap_if.dout,             16'h7FFE);
    sample(16'h7FFF);
    check("pos2.sat.dout",   sat_if.dout,              16'h7FFF);
    check("pos2.wrap.dout",  wrap_if.dout,             16'hFFFC);
    sample(16'h7FFF);
    sample(16'h7FFF);
    check("pos4.sat.dout",   sat_if.dout,              16'h7FFF);
    check("pos4.sat.o_ovr",  16'(sat_if.o_ovr),        16'h1);
    check("pos4.sat.sticky", 16'(sat_if.o_ovr_sticky), 16'h1);
    check("pos4.wrap.dout",  wrap_if.dout,             16'hFFF8);
    check("pos4.wrap.o_ovr", 16'(wrap_if.o_ovr),       16'h1);
    tick();
    check("idle.o_valid", 16'(sat_if.o_valid), 16'h0);
    check("idle.o_ovr",   16'(sat_if.o_ovr),   16'h1);
    check("idle.dout",    sat_if.dout,         16'h7FFF);
    flush = 1'b1;
    tick();
    check("flush2.o_ovr",  16'(sat_if.o_ovr),        16'h0);
    check("flush2.sticky", 16'(sat_if.o_ovr_sticky), 16'h1);

    sample(16'h8000);
    check("neg1.sat.dout",  sat_if.dout,       16'h8001);
    check("neg1.sat.o_ovr", 16'(sat_if.o_ovr), 16'h0);
    check("neg1.wrap.dout", wrap_if.dout,      16'h8001);
    repeat (3) sample(16'h8000);
    check("neg4.sat.dout",   sat_if.dout,        16'h8000);
    check("neg4.sat.o_ovr",  16'(sat_if.o_ovr),  16'h1);
    check("neg4.wrap.dout",  wrap_if.dout,       16'h0004);
    check("neg4.wrap.o_ovr", 16'(wrap_if.o_ovr), 16'h1);

    // ---- Sticky flag clear / set-wins ----------------------------------------
    flush = 1'b1;
    tick();
    ovr_clr = 1'b1;
    tick();
    check("clr_alone.sticky", 16'(sat_if.o_ovr_sticky), 16'h0);
    sample(16'h7FFF);
    check("clr_pre.sticky", 16'(sat_if.o_ovr_sticky), 16'h0);
    ovr_clr = 1'b1;
    sample(16'h7FFF);
    check("set_wins.o_ovr",  16'(sat_if.o_ovr),        16'h1);
    check("set_wins.sticky", 16'(sat_if.o_ovr_sticky), 16'h1);
    ovr_clr = 1'b1;
    tick();
    check("clr2.sticky", 16'(sat_if.o_ovr_sticky), 16'h0);
    check("clr2.o_ovr",  16'(sat_if.o_ovr),        16'h1);

    // Upstream overflow tag passes through with a clean sample.
    flush = 1'b1;
    tick();
    i_ovr = 1'b1;
    sample(16'h0000);
    check("i_ovr.dout",   sat_if.dout,              16'h0);
    check("i_ovr.o_ovr",  16'(sat_if.o_ovr),        16'h1);
    check("i_ovr.sticky", 16'(sat_if.o_ovr_sticky), 16'h1);
    sample(16'h0000);
    check("i_ovr_off.o_ovr",  16'(sat_if.o_ovr),        16'h0);
    check("i_ovr_off.sticky", 16'(sat_if.o_ovr_sticky), 16'h1);

    // ---- Reset mid-stream ----------------------------------------------------
    sample(16'h7FFF);
    #3 rstn = 1'b0;
    #1;
    check("mid_rst.o_valid", 16'(sat_if.o_valid),      16'h0);
    check("mid_rst.dout",    sat_if.dout,              16'h0);
    check("mid_rst.o_ovr",   16'(sat_if.o_ovr),        16'h0);
    check("mid_rst.sticky",  16'(sat_if.o_ovr_sticky), 16'h0);
    tick();
    rstn = 1'b1;
    sample(16'h7FFF);
    check("post_rst.o_valid", 16'(sat_if.o_valid), 16'h1);
    check("post_rst.dout",    sat_if.dout,         16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/transposed_fir_stream.md
Name: transposed_fir_stream

Overview:
Parametrised, valid-gated transposed-form FIR for the adaptive-filter datapath. Signed fixed-point samples use format WIDTH/FRAC. The block adds four things:
- Runtime coefficient loading through a double-buffered (shadow/active) bank.
- A selectable saturate/wrap output stage with round-half-up.
- A registered output with valid.
- A sticky overflow flag, plus a synchronous flush of the filter state.

Parameters:
WIDTH, 16, sample/coefficient/output width (signed two's complement)
FRAC, 15, fractional bits of din, coefficients and dout
TAPS, 8, number of taps (>=2)
SATURATE, 1, 1 = clamp on output overflow, 0 = wrap (two's complement truncation)

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
i_valid  in  1  din/i_ovr accepted this cycle; filter advances only when high
din  in  WIDTH  input sample x[n]
i_ovr  in  1  upstream overflow tag travelling with din
flush  in  1  synchronous clear of partial sums and output (coefficients kept)
coef_we  in  1  write coef_data into shadow bank at coef_addr
coef_addr  in  $clog2(TAPS)  tap index k (k=0 multiplies newest sample)
coef_data  in  WIDTH  coefficient value
coef_commit  in  1  copy whole shadow bank into active bank
o_valid  out  1  dout/o_ovr valid
dout  out  WIDTH  filtered sample y[n]
o_ovr  out  1  overflow tag aligned with dout
o_ovr_sticky  out  1  set by any o_ovr, held until ovr_clr
ovr_clr  in  1  clear sticky flag

Behaviour:
- Reset (rstn low, async) clears all of the following to 0:
  - Outputs: o_valid, dout, o_ovr, o_ovr_sticky.
  - State: partial sums, shadow bank, active bank.
- Reset mid-stream discards all in-flight data. Reset is released synchronously by design convention.
- Arithmetic:
  - Product c[k]*x is full precision: 2*WIDTH bits, 2*FRAC fractional bits.
  - Accumulator width is ACC = 2*WIDTH + $clog2(TAPS). Accumulation never overflows internally.
- Structure:
  - On an accepted sample x: s[j] <= c[j]*x + s[j+1] for j = 1..TAPS-2, and s[TAPS-1] <= c[TAPS-1]*x.
  - acc = c[0]*x + s[1].
  - This gives y[n] = sum over k of c[k]*x[n-k].
- When i_valid is low, all s[j] hold and o_valid is 0 on the next cycle. dout holds its last value.
- Latency: 1 cycle. An accepted sample on edge N produces o_valid=1, dout=y[n] after edge N+1 (registered).
- Output conversion:
  - Add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up).
  - If the result falls outside the signed WIDTH range, conversion overflow is flagged.
  - SATURATE=1 clamps to 2^(WIDTH-1)-1 or -2^(WIDTH-1). SATURATE=0 keeps the low WIDTH bits.
- o_ovr = registered (i_ovr | conversion overflow), aligned with dout. It updates only on accepted samples and holds otherwise.
- Sticky flag: o_ovr_sticky sets on any cycle where the registered o_ovr is written to 1. ovr_clr clears it. Set wins over simultaneous clear.
- Coefficient write:
  - coef_we writes shadow[coef_addr] at the edge.
  - coef_addr >= TAPS is ignored.
  - The shadow bank never affects the datapath directly.
- Coefficient commit:
  - coef_commit copies all of shadow into active at the edge.
  - A coef_we in the same cycle is included in the commit (write-through).
  - A sample accepted in the commit cycle uses the OLD active bank. The next sample uses the new bank.
  - The following TAPS-1 outputs mix products from both banks; this transient is expected and is not flagged.
- Flush:
  - Clears s[], dout, o_ovr and o_valid at the edge. Coefficients and the sticky flag are untouched.
  - A sample presented with flush in the same cycle is dropped.
  - Flush has priority over i_valid.
- No backpressure: the block accepts one sample per cycle, every cycle.

Test Plan:
- Reset: assert rstn=0 mid-stream -> dout=0, o_valid=0, o_ovr=0, o_ovr_sticky=0 immediately. The first output after release uses all-zero coefficients, giving dout=0.
- Impulse, TAPS=4:
  - Setup: write shadow = 0x4000, 0x2000, 0x1000, 0x0800 and commit; then din=0x7FFF for 1 sample, then zeros.
  - Response: dout = 0x4000, 0x2000, 0x1000, 0x0800, then 0x0000 (rounding verified), each with o_valid=1 one cycle after its i_valid.
- Valid gaps: repeat the impulse with i_valid low for 3 cycles between samples -> identical output sequence. o_valid=0 during gaps and dout holds.
- Saturation, all coefficients 0x7FFF:
  - Input 0x7FFF x4 -> fourth output 0x7FFF with o_ovr=1 and sticky=1.
  - Input 0x8000 x4 -> 0x8000 (clamped).
  - SATURATE=0 -> wrapped low WIDTH bits, o_ovr=1.
- Coefficient commit:
  - Write shadow without commit -> outputs unchanged.
  - Commit together with i_valid -> that sample uses old coefficients, the next sample uses new ones.
  - Write and commit in the same cycle -> the new value is active.
- Flush and clear:
  - Flush mid-impulse -> remaining impulse tail is 0.
  - ovr_clr in the same cycle as a new overflow -> sticky stays 1. ovr_clr alone -> sticky goes to 0.
